// File: rtl/mem_pkg.sv
// mem_pkg
// Shared definitions for the data-memory access unit.
//   - Size encodings carried on req_size (byte, half, word).
//   - FSM state encoding used by mem_subword_rmw.
//   - lane_mask(): which bytes of a word an access touches.
//   - access_bad(): illegal size or misaligned address detection.
package mem_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RD   = 2'd1,
      ST_WR   = 2'd2,
      ST_RESP = 2'd3
   } state_t;

   // Byte-enable mask for a size/offset pair, bit i covers bits [8i+7:8i]
   // of the word (little-endian lanes). Illegal sizes touch nothing.
   function automatic logic [3:0] lane_mask(input logic [1:0] size,
                                            input logic [1:0] lane);
      logic [3:0] mask;
      mask = 4'b0000;
      case (size)
         SZ_BYTE: mask = 4'b0001 << lane;
         SZ_HALF: mask = lane[1] ? 4'b1100 : 4'b0011;
         SZ_WORD: mask = 4'b1111;
         default: mask = 4'b0000;
      endcase
      return mask;
   endfunction

   // An access is rejected if its size is illegal or it is not naturally
   // aligned to its own size.
   function automatic logic access_bad(input logic [1:0] size,
                                       input logic [1:0] lane);
      logic bad;
      bad = 1'b0;
      case (size)
         SZ_BYTE: bad = 1'b0;
         SZ_HALF: bad = lane[0];
         SZ_WORD: bad = (lane != 2'b00);
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/mem_load_ext.sv
// mem_load_ext
// Combinational load lane extractor. Picks the addressed byte or halfword
// out of a full memory word and sign- or zero-extends it to 32 bits.
// Ports:
//   size   in  2   access size (SZ_BYTE / SZ_HALF / SZ_WORD)
//   uns    in  1   1 = zero-extend, 0 = sign-extend (ignored for words)
//   lane   in  2   byte offset of the access inside the word
//   word   in  32  full word read from memory
//   ext32  out 32  extended load result
module mem_load_ext
   import mem_pkg::*;
(
   input  logic [1:0]  size,
   input  logic        uns,
   input  logic [1:0]  lane,
   input  logic [31:0] word,
   output logic [31:0] ext32
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Lane select then extend. A half only ever sits at offset 0 or 2, so
   // lane[1] alone picks which 16 bits; the fill bit is the lane's top bit
   // masked off for unsigned loads.
   always_comb begin
      byte_sel = word[{lane, 3'b000} +: 8];
      half_sel = word[{lane[1], 4'b0000} +: 16];
      ext32    = word;
      case (size)
         SZ_BYTE: ext32 = {{24{byte_sel[7] & ~uns}}, byte_sel};
         SZ_HALF: ext32 = {{16{half_sel[15] & ~uns}}, half_sel};
         default: ext32 = word;
      endcase
   end

endmodule

// File: rtl/mem_subword_rmw.sv
// mem_subword_rmw
// Data-memory access unit between the CPU datapath and a word-only RAM.
// Stores narrower than a word are done as read-modify-write; loads pull the
// addressed lane out of the word and extend it to 32 bits. A watchdog aborts
// accesses the memory never acknowledges.
// Ports:
//   clk, rst      clock (rising edge), asynchronous active-high reset
//   req_valid     CPU request present
//   req_ready     unit idle and able to accept a request
//   req_we        1 = store, 0 = load
//   req_size      00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned  loads: 1 = zero-extend, 0 = sign-extend
//   req_addr      byte address
//   req_wdata     store data, byte/half in the low bits
//   resp_valid    one-cycle completion pulse
//   resp_rdata    extended load data, 0 for stores and errors
//   resp_err      misaligned, illegal size or timeout
//   mem_addr      word-aligned memory address
//   mem_rd        read strobe, held until mem_ack
//   mem_wr        write strobe, held until mem_ack
//   mem_wdata     full word to write
//   mem_rdata     read data, valid with mem_ack during a read
//   mem_ack       memory completes the current strobe
module mem_subword_rmw
   import mem_pkg::*;
#(
   parameter int AW      = 32,
   parameter int TIMEOUT = 255
)(
   input  logic          clk,
   input  logic          rst,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic          req_we,
   input  logic [1:0]    req_size,
   input  logic          req_unsigned,
   input  logic [AW-1:0] req_addr,
   input  logic [31:0]   req_wdata,
   output logic          resp_valid,
   output logic [31:0]   resp_rdata,
   output logic          resp_err,
   output logic [AW-1:0] mem_addr,
   output logic          mem_rd,
   output logic          mem_wr,
   output logic [31:0]   mem_wdata,
   input  logic [31:0]   mem_rdata,
   input  logic          mem_ack
);

   // The counter only has to reach TIMEOUT-1: it holds the number of strobe
   // cycles already completed, so expiry is flagged in the TIMEOUT-th cycle.
   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] WDOG_LAST = CW'(TIMEOUT - 1);

   state_t        state;
   logic [1:0]    lane_q;
   logic [1:0]    size_q;
   logic          we_q;
   logic          uns_q;
   logic [15:0]   wdata_q;
   logic [CW-1:0] wdog_cnt;

   logic [31:0]   load_word;
   logic [31:0]   merged_word;
   logic [31:0]   store_rep;
   logic [3:0]    store_mask;
   logic          wdog_expired;

   mem_load_ext u_load_ext (
      .size  (size_q),
      .uns   (uns_q),
      .lane  (lane_q),
      .word  (mem_rdata),
      .ext32 (load_word)
   );

   // Store merge: replicate the store data across every lane of its size so
   // the byte mask alone decides which bytes come from the CPU and which are
   // kept untouched from the word just read.
   always_comb begin
      store_mask  = lane_mask(size_q, lane_q);
      store_rep   = (size_q == SZ_BYTE) ? {4{wdata_q[7:0]}} : {2{wdata_q}};
      merged_word = mem_rdata;
      for (int i = 0; i < 4; i++) begin
         if (store_mask[i]) begin
            merged_word[8*i +: 8] = store_rep[8*i +: 8];
         end
      end
   end

   // A TIMEOUT of zero disables the watchdog entirely.
   assign wdog_expired = (TIMEOUT != 0) && (wdog_cnt == WDOG_LAST);

   // Main FSM with registered outputs. Every strobe and response flag is
   // set on the edge that enters its state and cleared on the edge that
   // leaves it, so mem_rd and mem_wr can never overlap and mem_addr only
   // changes on acceptance. In RD/WR an ack takes priority over watchdog
   // expiry, and the watchdog restarts from zero on every state change.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         req_ready  <= 1'b1;
         resp_valid <= 1'b0;
         resp_rdata <= '0;
         resp_err   <= 1'b0;
         mem_addr   <= '0;
         mem_rd     <= 1'b0;
         mem_wr     <= 1'b0;
         mem_wdata  <= '0;
         lane_q     <= '0;
         size_q     <= '0;
         we_q       <= 1'b0;
         uns_q      <= 1'b0;
         wdata_q    <= '0;
         wdog_cnt   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (req_valid && req_ready) begin
                  req_ready  <= 1'b0;
                  mem_addr   <= {req_addr[AW-1:2], 2'b00};
                  lane_q     <= req_addr[1:0];
                  size_q     <= req_size;
                  we_q       <= req_we;
                  uns_q      <= req_unsigned;
                  wdata_q    <= req_wdata[15:0];
                  wdog_cnt   <= '0;
                  resp_rdata <= '0;
                  if (access_bad(req_size, req_addr[1:0])) begin
                     state      <= ST_RESP;
                     resp_valid <= 1'b1;
                     resp_err   <= 1'b1;
                  end else if (!req_we || (req_size != SZ_WORD)) begin
                     state  <= ST_RD;
                     mem_rd <= 1'b1;
                  end else begin
                     state     <= ST_WR;
                     mem_wr    <= 1'b1;
                     mem_wdata <= req_wdata;
                  end
               end
            end

            ST_RD: begin
               if (mem_ack) begin
                  mem_rd   <= 1'b0;
                  wdog_cnt <= '0;
                  if (we_q) begin
                     state     <= ST_WR;
                     mem_wr    <= 1'b1;
                     mem_wdata <= merged_word;
                  end else begin
                     state      <= ST_RESP;
                     resp_valid <= 1'b1;
                     resp_rdata <= load_word;
                  end
               end else if (wdog_expired) begin
                  state      <= ST_RESP;
                  mem_rd     <= 1'b0;
                  wdog_cnt   <= '0;
                  resp_valid <= 1'b1;
                  resp_err   <= 1'b1;
               end else begin
                  wdog_cnt <= wdog_cnt + CW'(1);
               end
            end

            ST_WR: begin
               if (mem_ack) begin
                  state      <= ST_RESP;
                  mem_wr     <= 1'b0;
                  wdog_cnt   <= '0;
                  resp_valid <= 1'b1;
               end else if (wdog_expired) begin
                  state      <= ST_RESP;
                  mem_wr     <= 1'b0;
                  wdog_cnt   <= '0;
                  resp_valid <= 1'b1;
                  resp_err   <= 1'b1;
               end else begin
                  wdog_cnt <= wdog_cnt + CW'(1);
               end
            end

            ST_RESP: begin
               state      <= ST_IDLE;
               req_ready  <= 1'b1;
               resp_valid <= 1'b0;
               resp_err   <= 1'b0;
               resp_rdata <= '0;
               mem_wdata  <= '0;
            end

            default: begin
               state      <= ST_IDLE;
               req_ready  <= 1'b1;
               resp_valid <= 1'b0;
               resp_err   <= 1'b0;
               mem_rd     <= 1'b0;
               mem_wr     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_subword_rmw.sv
// tb_mem_subword_rmw
// Directed self-checking bench for mem_subword_rmw (TIMEOUT = 4).
// A small word memory answers strobes after a programmable number of wait
// cycles (or never), and a monitor counts strobe cycles and captured writes.
module tb_mem_subword_rmw;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic [31:0] mem_addr;
   logic        mem_rd;
   logic        mem_wr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata = '0;
   logic        mem_ack = 1'b0;

   logic [31:0] mem [0:63];
   int          ack_delay;
   int          strobe_wait = 0;

   int          rd_cycles = 0;
   int          wr_cycles = 0;
   int          wr_count = 0;
   int          overlap = 0;
   logic [31:0] last_rd_addr = '0;
   logic [31:0] last_wr_addr = '0;
   logic [31:0] last_wr_data = '0;

   int          checks = 0;
   int          failures = 0;

   int          lat;
   int          got;
   logic [31:0] obs_rdata;
   logic        obs_err;
   logic        post_ready;
   logic        post_valid;
   int          rd0;
   int          wr0;
   int          seen;

   mem_subword_rmw #(.AW(32), .TIMEOUT(4)) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_we       (req_we),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .resp_valid   (resp_valid),
      .resp_rdata   (resp_rdata),
      .resp_err     (resp_err),
      .mem_addr     (mem_addr),
      .mem_rd       (mem_rd),
      .mem_wr       (mem_wr),
      .mem_wdata    (mem_wdata),
      .mem_rdata    (mem_rdata),
      .mem_ack      (mem_ack)
   );

   always #5 clk = ~clk;

   // Memory responder: acks after ack_delay strobe cycles (negative = never),
   // driving ack and read data on the falling edge so they are stable by the
   // next rising edge.
   always @(negedge clk) begin
      mem_rdata <= mem[mem_addr[7:2]];
      if ((mem_rd || mem_wr) && (ack_delay >= 0) && (strobe_wait == ack_delay)) begin
         mem_ack     <= 1'b1;
         strobe_wait <= 0;
      end else begin
         mem_ack     <= 1'b0;
         strobe_wait <= (mem_rd || mem_wr) ? strobe_wait + 1 : 0;
      end
   end

   // Monitor: counts strobe cycles and records every completed write.
   always @(posedge clk) begin
      if (mem_rd) begin
         rd_cycles    <= rd_cycles + 1;
         last_rd_addr <= mem_addr;
      end
      if (mem_wr) wr_cycles <= wr_cycles + 1;
      if (mem_wr && mem_ack) begin
         wr_count     <= wr_count + 1;
         last_wr_addr <= mem_addr;
         last_wr_data <= mem_wdata;
      end
      if (mem_rd && mem_wr) overlap <= overlap + 1;
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
      end
   endtask

   // Issue one request, then wait (bounded) for the response. lat counts
   // falling edges after the acceptance edge, so a zero-wait load lands at
   // lat = 2 (acceptance, RD, RESP = three cycles).
   task automatic applyStimulus(input logic we, input logic [1:0] size,
                                input logic uns, input logic [31:0] addr,
                                input logic [31:0] wdata);
      @(negedge clk);
      rd0          = rd_cycles;
      wr0          = wr_count;
      req_valid    = 1'b1;
      req_we       = we;
      req_size     = size;
      req_unsigned = uns;
      req_addr     = addr;
      req_wdata    = wdata;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_wdata = 32'hFFFF_FFFF;
      req_addr  = 32'hFFFF_FFFF;
      got = 0;
      lat = 0;
      obs_rdata = '0;
      obs_err = 1'b0;
      for (int i = 0; i < 40 && got == 0; i++) begin
         @(negedge clk);
         lat++;
         if (resp_valid) begin
            got       = 1;
            obs_rdata = resp_rdata;
            obs_err   = resp_err;
         end
      end
      if (got == 0) checkOutput("resp_wait_bound", 32'd0, 32'd1);
      @(negedge clk);
      post_ready = req_ready;
      post_valid = resp_valid;
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL global_time_limit reached");
      $fatal(1, "[TB] simulation time limit");
   end

   initial begin
      rst          = 1'b1;
      req_valid    = 1'b0;
      req_we       = 1'b0;
      req_size     = 2'b00;
      req_unsigned = 1'b0;
      req_addr     = '0;
      req_wdata    = '0;
      ack_delay    = 0;
      for (int i = 0; i < 64; i++) mem[i] = 32'h0BAD_0000 + i;
      mem[4]  = 32'h80FF_7F01;
      mem[8]  = 32'hBEEF_1234;
      mem[16] = 32'h1122_3344;

      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("rst_ready",  {31'd0, req_ready},  32'd1);
      checkOutput("rst_valid",  {31'd0, resp_valid}, 32'd0);
      checkOutput("rst_err",    {31'd0, resp_err},   32'd0);
      checkOutput("rst_rdata",  resp_rdata,          32'd0);
      checkOutput("rst_strobe", {30'd0, mem_rd, mem_wr}, 32'd0);
      checkOutput("rst_addr",   mem_addr,            32'd0);
      checkOutput("rst_wdata",  mem_wdata,           32'd0);
      rst = 1'b0;

      // lb 0x13: top byte 0x80 sign-extended
      applyStimulus(1'b0, 2'b00, 1'b0, 32'h13, 32'h0);
      checkOutput("lb_rdata", obs_rdata, 32'hFFFF_FF80);
      checkOutput("lb_err",   {31'd0, obs_err}, 32'd0);
      checkOutput("lb_addr",  last_rd_addr, 32'h10);
      checkOutput("lb_lat",   lat, 32'd2);
      checkOutput("lb_reads", rd_cycles - rd0, 32'd1);
      checkOutput("lb_ready_after", {31'd0, post_ready}, 32'd1);
      checkOutput("lb_pulse_once",  {31'd0, post_valid}, 32'd0);

      // lbu 0x10: low byte 0x01
      applyStimulus(1'b0, 2'b00, 1'b1, 32'h10, 32'h0);
      checkOutput("lbu_rdata", obs_rdata, 32'h0000_0001);

      // lhu / lh at 0x22: upper half 0xBEEF
      applyStimulus(1'b0, 2'b01, 1'b1, 32'h22, 32'h0);
      checkOutput("lhu_rdata", obs_rdata, 32'h0000_BEEF);
      applyStimulus(1'b0, 2'b01, 1'b0, 32'h22, 32'h0);
      checkOutput("lh_rdata", obs_rdata, 32'hFFFF_BEEF);

      // lh at 0x20: lower half 0x1234 stays positive
      applyStimulus(1'b0, 2'b01, 1'b0, 32'h20, 32'h0);
      checkOutput("lh_low_rdata", obs_rdata, 32'h0000_1234);

      // sb 0x41 0xAA into 0x11223344
      applyStimulus(1'b1, 2'b00, 1'b0, 32'h41, 32'hFFFF_FFAA);
      checkOutput("sb_reads",  rd_cycles - rd0, 32'd1);
      checkOutput("sb_writes", wr_count - wr0, 32'd1);
      checkOutput("sb_wdata",  last_wr_data, 32'h1122_AA44);
      checkOutput("sb_waddr",  last_wr_addr, 32'h40);
      checkOutput("sb_lat",    lat, 32'd3);
      checkOutput("sb_rdata",  obs_rdata, 32'd0);
      checkOutput("sb_err",    {31'd0, obs_err}, 32'd0);

      // sh 0x22 0x5566 into 0xBEEF1234
      applyStimulus(1'b1, 2'b01, 1'b0, 32'h22, 32'hABCD_5566);
      checkOutput("sh_wdata", last_wr_data, 32'h5566_1234);

      // sw 0x8: direct write, no read
      applyStimulus(1'b1, 2'b10, 1'b0, 32'h8, 32'hDEAD_BEEF);
      checkOutput("sw_reads",  rd_cycles - rd0, 32'd0);
      checkOutput("sw_writes", wr_count - wr0, 32'd1);
      checkOutput("sw_wdata",  last_wr_data, 32'hDEAD_BEEF);
      checkOutput("sw_waddr",  last_wr_addr, 32'h8);
      checkOutput("sw_lat",    lat, 32'd2);

      // lw 0x20 passes through, unsigned ignored
      applyStimulus(1'b0, 2'b10, 1'b1, 32'h20, 32'h0);
      checkOutput("lw_rdata", obs_rdata, 32'hBEEF_1234);

      // lh at 0x3: misaligned, no strobe, response in the next cycle
      applyStimulus(1'b0, 2'b01, 1'b0, 32'h3, 32'h0);
      checkOutput("mis_err",     {31'd0, obs_err}, 32'd1);
      checkOutput("mis_rdata",   obs_rdata, 32'd0);
      checkOutput("mis_strobes", (rd_cycles - rd0) + (wr_count - wr0), 32'd0);
      checkOutput("mis_lat",     lat, 32'd1);

      // size 11: illegal
      applyStimulus(1'b1, 2'b11, 1'b0, 32'h0, 32'h1234_5678);
      checkOutput("ill_err",     {31'd0, obs_err}, 32'd1);
      checkOutput("ill_rdata",   obs_rdata, 32'd0);
      checkOutput("ill_strobes", (rd_cycles - rd0) + (wr_count - wr0), 32'd0);

      // sw at 0x2: misaligned word
      applyStimulus(1'b1, 2'b10, 1'b0, 32'h2, 32'h1234_5678);
      checkOutput("sw_mis_err",    {31'd0, obs_err}, 32'd1);
      checkOutput("sw_mis_writes", wr_count - wr0, 32'd0);

      // never ack: mem_rd for exactly 4 cycles, then an error response
      ack_delay = -1;
      applyStimulus(1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
      checkOutput("to_err",   {31'd0, obs_err}, 32'd1);
      checkOutput("to_rdata", obs_rdata, 32'd0);
      checkOutput("to_rd_cycles", rd_cycles - rd0, 32'd4);
      checkOutput("to_lat",   lat, 32'd5);

      // ack in the expiry cycle wins
      ack_delay = 3;
      applyStimulus(1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
      checkOutput("ackwin_err",   {31'd0, obs_err}, 32'd0);
      checkOutput("ackwin_rdata", obs_rdata, 32'hBEEF_1234);
      checkOutput("ackwin_lat",   lat, 32'd5);

      // sub-word store timing out in RD never writes
      ack_delay = -1;
      applyStimulus(1'b1, 2'b00, 1'b0, 32'h40, 32'h55);
      checkOutput("to_sb_err",    {31'd0, obs_err}, 32'd1);
      checkOutput("to_sb_writes", wr_count - wr0, 32'd0);

      // reset during WR: strobe drops at once, no response
      @(negedge clk);
      wr0          = wr_count;
      req_valid    = 1'b1;
      req_we       = 1'b1;
      req_size     = 2'b10;
      req_addr     = 32'h8;
      req_wdata    = 32'hCAFE_F00D;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      @(negedge clk);
      checkOutput("rstwr_active", {31'd0, mem_wr}, 32'd1);
      rst = 1'b1;
      #1;
      checkOutput("rstwr_wr_drop", {31'd0, mem_wr}, 32'd0);
      checkOutput("rstwr_ready",   {31'd0, req_ready}, 32'd1);
      @(negedge clk);
      rst = 1'b0;
      ack_delay = 0;
      seen = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (resp_valid) seen++;
      end
      checkOutput("rstwr_no_resp", seen, 32'd0);
      checkOutput("rstwr_writes",  wr_count - wr0, 32'd0);
      checkOutput("rstwr_idle",    {31'd0, req_ready}, 32'd1);

      // unit still works after the abort
      applyStimulus(1'b0, 2'b00, 1'b0, 32'h12, 32'h0);
      checkOutput("post_rst_lb", obs_rdata, 32'h0000_00FF & 32'hFFFF_FFFF | 32'hFFFF_FF00);

      checkOutput("no_overlap", overlap, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
